// File: rtl/rgb2ycbcr_pipe_if.sv
// Video stream bundle for the RGB-to-YCbCr converter: input syncs and pixel,
// delayed output syncs and converted components.
interface rgb2ycbcr_pipe_if;
  logic        pre_frame_vsync;
  logic        pre_frame_hsync;
  logic        pre_frame_de;
  logic [23:0] in_data;
  logic        post_frame_vsync;
  logic        post_frame_hsync;
  logic        post_frame_de;
  logic [7:0]  img_y;
  logic [7:0]  img_cb;
  logic [7:0]  img_cr;

  modport master (
    output pre_frame_vsync, pre_frame_hsync, pre_frame_de, in_data,
    input  post_frame_vsync, post_frame_hsync, post_frame_de,
    input  img_y, img_cb, img_cr
  );

  modport slave (
    input  pre_frame_vsync, pre_frame_hsync, pre_frame_de, in_data,
    output post_frame_vsync, post_frame_hsync, post_frame_de,
    output img_y, img_cb, img_cr
  );
endinterface

// File: rtl/rgb2ycbcr_pipe.sv
// Three-stage stallable RGB565/RGB888 to YCbCr converter with a colour standard
// latched on each vsync rising edge; syncs travel in lockstep with the data.
module rgb2ycbcr_pipe #(
  parameter int IN_FMT   = 0,
  parameter int ROUND_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [1:0]       mode_sel,
  rgb2ycbcr_pipe_if.slave  vid,
  output logic [1:0]       mode_active
);

  // Rows: mode 0..3 (3 aliases mode 0); columns: Y(R,G,B), Cb(R,G,B), Cr(R,G,B).
  localparam logic signed [9:0] COEF [4][9] = '{
    '{ 10'sd77,  10'sd150,  10'sd29, -10'sd43, -10'sd85, 10'sd128, 10'sd128, -10'sd107, -10'sd21},
    '{ 10'sd54,  10'sd183,  10'sd19, -10'sd29, -10'sd99, 10'sd128, 10'sd128, -10'sd116, -10'sd12},
    '{ 10'sd66,  10'sd129,  10'sd25, -10'sd38, -10'sd74, 10'sd112, 10'sd112, -10'sd94,  -10'sd18},
    '{ 10'sd77,  10'sd150,  10'sd29, -10'sd43, -10'sd85, 10'sd128, 10'sd128, -10'sd107, -10'sd21}
  };

  localparam logic signed [17:0] OFFS [4][3] = '{
    '{18'sd0,    18'sd32768, 18'sd32768},
    '{18'sd0,    18'sd32768, 18'sd32768},
    '{18'sd4096, 18'sd32768, 18'sd32768},
    '{18'sd0,    18'sd32768, 18'sd32768}
  };

  localparam logic signed [17:0] RND = (ROUND_EN != 0) ? 18'sd128 : 18'sd0;

  function automatic logic signed [17:0] mul_f(input logic [7:0] a, input logic signed [9:0] c);
    mul_f = $signed({10'd0, a}) * $signed({{8{c[9]}}, c});
  endfunction

  function automatic logic [7:0] clamp_f(input logic signed [17:0] s);
    logic [9:0] sh;
    sh = s[17:8];
    if (sh[9]) begin
      clamp_f = 8'd0;
    end else if (sh[8]) begin
      clamp_f = 8'hFF;
    end else begin
      clamp_f = sh[7:0];
    end
  endfunction

  logic [7:0]        pix_s [3];
  logic              vsync_edge_s;
  logic [1:0]        mode_next_s;
  logic              vsync_prev_r;
  logic [1:0]        mode_active_r;
  logic [1:0]        mode1_r;
  logic signed [17:0] prod_r [9];
  logic signed [17:0] sum_r  [3];
  logic [2:0]        sync1_r;
  logic [2:0]        sync2_r;
  logic [2:0]        sync3_r;
  logic [7:0]        y_r;
  logic [7:0]        cb_r;
  logic [7:0]        cr_r;

  // Expand the selected input format to three 8-bit channels by MSB replication.
  always_comb begin
    pix_s[0] = 8'd0;
    pix_s[1] = 8'd0;
    pix_s[2] = 8'd0;
    if (IN_FMT == 0) begin
      pix_s[0] = {vid.in_data[15:11], vid.in_data[15:13]};
      pix_s[1] = {vid.in_data[10:5],  vid.in_data[10:9]};
      pix_s[2] = {vid.in_data[4:0],   vid.in_data[4:2]};
    end else begin
      pix_s[0] = vid.in_data[23:16];
      pix_s[1] = vid.in_data[15:8];
      pix_s[2] = vid.in_data[7:0];
    end
  end

  // The mode taken on a vsync rise applies to the pixel arriving in that same cycle.
  always_comb begin
    vsync_edge_s = ce & vid.pre_frame_vsync & ~vsync_prev_r;
    mode_next_s  = mode_active_r;
    if (vsync_edge_s) begin
      mode_next_s = (mode_sel == 2'd3) ? 2'd0 : mode_sel;
    end else begin
      mode_next_s = mode_active_r;
    end
  end

  // Mode latch, three pipeline stages and the sync delay line, all frozen by ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev_r  <= 1'b0;
      mode_active_r <= 2'd0;
      mode1_r       <= 2'd0;
      for (int k = 0; k < 9; k++) prod_r[k] <= 18'sd0;
      for (int c = 0; c < 3; c++) sum_r[c] <= 18'sd0;
      sync1_r <= 3'd0;
      sync2_r <= 3'd0;
      sync3_r <= 3'd0;
      y_r     <= 8'd0;
      cb_r    <= 8'd0;
      cr_r    <= 8'd0;
    end else if (ce) begin
      vsync_prev_r  <= vid.pre_frame_vsync;
      mode_active_r <= mode_next_s;
      mode1_r       <= mode_next_s;
      for (int k = 0; k < 9; k++) prod_r[k] <= mul_f(pix_s[k % 3], COEF[mode_next_s][k]);
      for (int c = 0; c < 3; c++) begin
        sum_r[c] <= OFFS[mode1_r][c] + prod_r[3*c] + prod_r[3*c+1] + prod_r[3*c+2] + RND;
      end
      sync1_r <= {vid.pre_frame_vsync, vid.pre_frame_hsync, vid.pre_frame_de};
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      // Components are blanked by de only; hsync plays no part in gating.
      y_r  <= sync2_r[0] ? clamp_f(sum_r[0]) : 8'd0;
      cb_r <= sync2_r[0] ? clamp_f(sum_r[1]) : 8'd0;
      cr_r <= sync2_r[0] ? clamp_f(sum_r[2]) : 8'd0;
    end
  end

  assign vid.post_frame_vsync = sync3_r[2];
  assign vid.post_frame_hsync = sync3_r[1];
  assign vid.post_frame_de    = sync3_r[0];
  assign vid.img_y            = y_r;
  assign vid.img_cb           = cb_r;
  assign vid.img_cr           = cr_r;
  assign mode_active          = mode_active_r;

endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// Scoreboard bench for rgb2ycbcr_pipe: an RGB888 and an RGB565 instance share
// stimulus; a reference model predicts outputs three accepted cycles later.
module tb_rgb2ycbcr_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [1:0]  mode_sel = 2'd0;
  logic        vs = 1'b0;
  logic        hs = 1'b0;
  logic        de = 1'b0;
  logic [23:0] din = 24'd0;
  logic [1:0]  mode8;
  logic [1:0]  mode5;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  rgb2ycbcr_pipe_if vif8 ();
  rgb2ycbcr_pipe_if vif5 ();

  assign vif8.pre_frame_vsync = vs;
  assign vif8.pre_frame_hsync = hs;
  assign vif8.pre_frame_de    = de;
  assign vif8.in_data         = din;
  assign vif5.pre_frame_vsync = vs;
  assign vif5.pre_frame_hsync = hs;
  assign vif5.pre_frame_de    = de;
  assign vif5.in_data         = din;

  rgb2ycbcr_pipe #(.IN_FMT(1), .ROUND_EN(1)) u_dut8 (
    .clk(clk), .rst(rst), .ce(ce), .mode_sel(mode_sel), .vid(vif8.slave), .mode_active(mode8)
  );
  rgb2ycbcr_pipe #(.IN_FMT(0), .ROUND_EN(1)) u_dut5 (
    .clk(clk), .rst(rst), .ce(ce), .mode_sel(mode_sel), .vid(vif5.slave), .mode_active(mode5)
  );

  typedef struct {
    logic vs, hs, de;
    int   y8, cb8, cr8, y5, cb5, cr5;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   m_mode = 0;
  logic m_pvs = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model(input logic [23:0] d, input int fmt, input int m,
                                output int y, output int cb, output int cr);
    int k[9];
    int o[3];
    int r, g, b;
    int v[3];
    case (m)
      1: begin k = '{54, 183, 19, -29, -99, 128, 128, -116, -12}; o = '{0, 32768, 32768}; end
      2: begin k = '{66, 129, 25, -38, -74, 112, 112, -94, -18};  o = '{4096, 32768, 32768}; end
      default: begin k = '{77, 150, 29, -43, -85, 128, 128, -107, -21}; o = '{0, 32768, 32768}; end
    endcase
    if (fmt == 0) begin
      r = int'(d[15:11]) * 8 + int'(d[15:11]) / 4;
      g = int'(d[10:5]) * 4 + int'(d[10:5]) / 16;
      b = int'(d[4:0]) * 8 + int'(d[4:0]) / 4;
    end else begin
      r = int'(d[23:16]);
      g = int'(d[15:8]);
      b = int'(d[7:0]);
    end
    for (int c = 0; c < 3; c++) begin
      v[c] = (o[c] + k[3*c]*r + k[3*c+1]*g + k[3*c+2]*b + 128) >>> 8;
      if (v[c] < 0) v[c] = 0;
      if (v[c] > 255) v[c] = 255;
    end
    y = v[0]; cb = v[1]; cr = v[2];
  endfunction

  task automatic step(input logic r_in, input logic ce_in, input logic [1:0] sel_in,
                      input logic vs_in, input logic hs_in, input logic de_in, input logic [23:0] d_in);
    exp_t e;
    rst = r_in; ce = ce_in; mode_sel = sel_in;
    vs = vs_in; hs = hs_in; de = de_in; din = d_in;
    @(posedge clk);
    #1;
    if (r_in) begin
      q.delete();
      last = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
      m_mode = 0;
      m_pvs = 1'b0;
    end else if (ce_in) begin
      if (vs_in && !m_pvs) m_mode = (sel_in == 2'd3) ? 0 : int'(sel_in);
      m_pvs = vs_in;
      e.vs = vs_in; e.hs = hs_in; e.de = de_in;
      model(d_in, 1, m_mode, e.y8, e.cb8, e.cr8);
      model(d_in, 0, m_mode, e.y5, e.cb5, e.cr5);
      if (!de_in) begin
        e.y8 = 0; e.cb8 = 0; e.cr8 = 0; e.y5 = 0; e.cb5 = 0; e.cr5 = 0;
      end
      q.push_back(e);
      if (q.size() == 3) last = q.pop_front();
    end
    chk("vsync8", vif8.post_frame_vsync, last.vs);
    chk("hsync8", vif8.post_frame_hsync, last.hs);
    chk("de8",    vif8.post_frame_de,    last.de);
    chk("y888",   vif8.img_y,  last.y8);
    chk("cb888",  vif8.img_cb, last.cb8);
    chk("cr888",  vif8.img_cr, last.cr8);
    chk("de5",    vif5.post_frame_de,    last.de);
    chk("vsync5", vif5.post_frame_vsync, last.vs);
    chk("y565",   vif5.img_y,  last.y5);
    chk("cb565",  vif5.img_cb, last.cb5);
    chk("cr565",  vif5.img_cr, last.cr5);
    chk("mode8",  mode8, m_mode);
    chk("mode5",  mode5, m_mode);
  endtask

  initial begin
    last = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 24'd0);
    step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 24'd0);
    // Frame in mode 0: white, black, pure red (565) and assorted colours.
    step(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 24'd0);
    step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 24'hFFFFFF);
    step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 24'h000000);
    step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 24'h00F800);
    step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 24'hFF0000);
    step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 24'h0000FF);
    step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 24'h00FF00);
    // mode_sel changes mid-frame without effect.
    step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 24'hFF0000);
    step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 24'h123456);
    step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 24'hABCDEF);
    // Vsync rise with a live pixel: that pixel already uses mode 1.
    step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 24'hFF0000);
    step(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 24'h80FF40);
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 24'hFFFFFF);
    step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 24'h000000);
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 24'hFFFFFF);
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 24'h00FFFF);
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 24'hFF00FF);
    step(1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 24'hF8001F);
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 24'hFFFFFF);
    // Ramp with random stalls, random mode requests and vsync pulses.
    for (int i = 0; i < 160; i++) begin
      step(1'b0, ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
           ((i % 37) < 2), ((i % 16) < 2), ((i % 11) != 0), 24'(i * 24'h030507));
    end
    // Edge coinciding with ce = 0 is taken once ce returns.
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 24'h445566);
    step(1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 24'h778899);
    step(1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 24'h778899);
    step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 24'h778899);
    // Reset with a full pipeline while vsync stays high through deassertion.
    step(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 24'hFFFFFF);
    step(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 24'h102030);
    step(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 24'hFFFFFF);
    step(1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 24'hFFFFFF);
    step(1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 24'hFFFFFF);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, (i != 2), 2'd1, 1'b1, 1'b0, (i != 4), 24'(24'hFF0000 - i * 24'h010203));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 24'h0);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
